debug_host: RTL and testbench

- Host-side controller for the CPU single-step debug port: drives `debug_en`, `debug_step` and `debug_addr`, and samples `debug_data`.
- On request it issues one clean CPU step pulse, or dumps a window of debug words.
- Each dumped word is sent as ASCII hex over a UART TX line.
- Sits at board top level beside the CPU, fed by debounced button pulses.

---
 rtl/debug_host_pkg.sv | 15 +
 rtl/debug_host_uart_tx_byte.sv | 74 +++++++
 rtl/debug_host.sv | 172 +++++++++++++++++
 tb/tb_debug_host.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_host_pkg.sv
// Shared state encoding and ASCII constants for the CPU debug host.
package debug_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_STEP_H, S_STEP_L, S_ADDR, S_WAIT,
    S_CHAR, S_CHWAIT, S_EOL_CR, S_EOL_LF, S_DONE
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

endpackage

// File: rtl/debug_host_uart_tx_byte.sv
// 8N1 UART transmitter for one byte; done pulses in the last cycle of the stop bit.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          busy_q, busy_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    txd_d   = txd_q;
    bit_end = busy_q && (cnt_q == CW'(CLKS_PER_BIT - 1));
    done    = bit_end && (bit_q == 4'd9);
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        frame_d = {1'b1, data, 1'b0};
        cnt_d   = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
      end else begin
        // Frame shifts right so bit 1 is always the next bit on the wire.
        bit_d   = bit_q + 4'd1;
        frame_d = {1'b1, frame_q[9:1]};
        txd_d   = frame_q[1];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: rtl/debug_host.sv
// Host-side CPU single-step controller: issues step pulses and dumps debug words as hex over UART.
module debug_host
  import debug_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STEP_HI      = 4,
  parameter int STEP_LO      = 4,
  parameter int NUM_WORDS    = 32,
  parameter int SETTLE       = 2,
  parameter int AUTO_DUMP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_req,
  input  logic        dump_req,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        uart_txd,
  output logic        busy,
  output logic        dump_done
);

  localparam int CMAX0 = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
  localparam int CMAX  = (CMAX0 > SETTLE) ? CMAX0 : SETTLE;
  localparam int CW    = $clog2(CMAX + 1);

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_0 + 8'(n) : ASCII_A + 8'(n - 4'd10);
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [3:0]    nib_q, nib_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [6:0]    addr_q, addr_d;
  logic          step_q, step_d;
  logic          en_q;

  logic          tx_start, tx_busy, tx_done;
  logic [7:0]    tx_data;
  logic [2:0]    nib_sel;
  logic [3:0]    nibble;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    nib_d    = nib_q;
    shadow_d = shadow_q;
    addr_d   = addr_q;
    step_d   = step_q;
    tx_start = 1'b0;
    tx_data  = ASCII_SPACE;
    // Nibble 0 is the most significant hex digit.
    nib_sel  = 3'd7 - nib_q[2:0];
    nibble   = shadow_q[{nib_sel, 2'b00} +: 4];
    case (state_q)
      S_IDLE: begin
        if (step_req) begin
          step_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_STEP_H;
        end else if (dump_req) begin
          idx_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_STEP_H: begin
        if (cnt_q == CW'(STEP_HI - 1)) begin
          step_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_STEP_L;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_STEP_L: begin
        if (cnt_q == CW'(STEP_LO - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (AUTO_DUMP != 0) ? S_ADDR : S_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_ADDR: begin
        addr_d  = idx_q[6:0];
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          shadow_d = debug_data;
          nib_d    = '0;
          state_d  = S_CHAR;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_CHAR: begin
        tx_data  = (nib_q == 4'd8) ? ASCII_SPACE : hex_ascii(nibble);
        tx_start = !tx_busy;
        if (!tx_busy) state_d = S_CHWAIT;
      end
      S_CHWAIT: begin
        if (tx_done) begin
          if (nib_q != 4'd8) begin
            nib_d   = nib_q + 4'd1;
            state_d = S_CHAR;
          end else if (idx_q == 8'(NUM_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_EOL_CR;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_EOL_CR, S_EOL_LF: begin
        // cnt_q marks whether this line-end byte has already been launched.
        tx_data  = (state_q == S_EOL_CR) ? ASCII_CR : ASCII_LF;
        tx_start = (cnt_q == '0) && !tx_busy;
        if (tx_start) cnt_d = CW'(1);
        if (tx_done) begin
          cnt_d   = '0;
          state_d = (state_q == S_EOL_CR) ? S_EOL_LF : S_DONE;
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      nib_q    <= '0;
      shadow_q <= '0;
      addr_q   <= '0;
      step_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      nib_q    <= nib_d;
      shadow_q <= shadow_d;
      addr_q   <= addr_d;
      step_q   <= step_d;
      en_q     <= 1'b1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_data),
    .txd   (uart_txd),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  assign debug_en   = en_q;
  assign debug_step = step_q;
  assign debug_addr = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign dump_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_debug_host.sv
// Bench for debug_host: one instance without and one with automatic dump after step.
module tb_debug_host;
  localparam int CPB = 4;
  localparam int NW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        step_req [2];
  logic        dump_req [2];
  logic        debug_en [2];
  logic        debug_step [2];
  logic [6:0]  debug_addr [2];
  logic [31:0] debug_data [2];
  logic        uart_txd [2];
  logic        busy [2];
  logic        dump_done [2];
  logic [31:0] mem [128];

  assign debug_data[0] = mem[debug_addr[0]];
  assign debug_data[1] = mem[debug_addr[1]];

  debug_host #(.CLKS_PER_BIT(CPB), .STEP_HI(4), .STEP_LO(4), .NUM_WORDS(NW),
               .SETTLE(2), .AUTO_DUMP(0)) dut0 (
    .clk(clk), .rst(rst), .step_req(step_req[0]), .dump_req(dump_req[0]),
    .debug_en(debug_en[0]), .debug_step(debug_step[0]), .debug_addr(debug_addr[0]),
    .debug_data(debug_data[0]), .uart_txd(uart_txd[0]), .busy(busy[0]),
    .dump_done(dump_done[0]));

  debug_host #(.CLKS_PER_BIT(CPB), .STEP_HI(4), .STEP_LO(4), .NUM_WORDS(NW),
               .SETTLE(2), .AUTO_DUMP(1)) dut1 (
    .clk(clk), .rst(rst), .step_req(step_req[1]), .dump_req(dump_req[1]),
    .debug_en(debug_en[1]), .debug_step(debug_step[1]), .debug_addr(debug_addr[1]),
    .debug_data(debug_data[1]), .uart_txd(uart_txd[1]), .busy(busy[1]),
    .dump_done(dump_done[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitors: step edges, dump_done pulses, and a UART receiver sampling every cycle.
  logic [7:0]  rxq [2][$];
  int          rises [2];
  int          dones [2];
  logic        prev_step [2];
  bit          in_fr [2];
  int          nsm [2];
  logic [39:0] smp [2];
  bit          got41 = 1'b0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        in_fr[d]     = 1'b0;
        prev_step[d] = 1'b0;
      end else begin
        if (debug_step[d] && !prev_step[d]) rises[d]++;
        prev_step[d] = debug_step[d];
        if (dump_done[d]) dones[d]++;
        if (in_fr[d]) begin
          smp[d][nsm[d]] = uart_txd[d];
          nsm[d]++;
          if (nsm[d] == 40) begin
            logic       ok;
            logic [9:0] fr;
            logic [7:0] b;
            ok = 1'b1;
            for (int f = 0; f < 10; f++) begin
              for (int k = 1; k < CPB; k++)
                if (smp[d][f*CPB+k] !== smp[d][f*CPB]) ok = 1'b0;
              fr[9-f] = smp[d][f*CPB];
            end
            for (int i = 0; i < 8; i++) b[i] = fr[8-i];
            chk("uart_bit_width", ok, 1);
            chk("uart_start_stop", {fr[9], fr[0]}, 2'b01);
            if (b == 8'h41 && !got41) begin
              chk("frame_0x41", fr, 10'b0100000101);
              got41 = 1'b1;
            end
            rxq[d].push_back(b);
            in_fr[d] = 1'b0;
          end
        end else if (uart_txd[d] == 1'b0) begin
          in_fr[d]     = 1'b1;
          smp[d][0]    = 1'b0;
          nsm[d]       = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int d, input logic st, input logic du);
    step_req[d] = st;
    dump_req[d] = du;
    @(negedge clk);
    step_req[d] = 1'b0;
    dump_req[d] = 1'b0;
  endtask

  task automatic clear_mon(input int d);
    rxq[d].delete();
    rises[d] = 0;
    dones[d] = 0;
  endtask

  task automatic wait_done(input int d);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (dump_done[d]) break;
    end
    chk($sformatf("dump_done_seen%0d", d), i < 4000, 1);
  endtask

  // Expected dump text: each word as 8 uppercase hex digits plus a space, then CR LF.
  task automatic check_dump(input int d, input string tag);
    string      hx;
    logic [7:0] exp_q [$];
    hx = "0123456789ABCDEF";
    for (int w = 0; w < NW; w++) begin
      for (int n = 7; n >= 0; n--) exp_q.push_back(hx[(mem[w] >> (4*n)) & 32'hF]);
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    chk({tag, "_len"}, rxq[d].size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rxq[d].size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rxq[d][i], exp_q[i]);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      step_req[d] = 1'b0;
      dump_req[d] = 1'b0;
    end
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_00AF;
    mem[1] = 32'h1234_5678;

    tick(3);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outs%0d", d),
          {debug_en[d], debug_step[d], debug_addr[d], uart_txd[d], busy[d], dump_done[d]},
          {1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    tick(1);
    chk("en_after_reset", {debug_en[0], debug_en[1]}, 2'b11);

    // Reset in the middle of a character must abort the dump cleanly.
    pulse(1, 1'b0, 1'b1);
    tick(60);
    rst = 1'b0;
    tick(3);
    clear_mon(1);
    rst = 1'b1;
    chk("midreset_outs", {debug_en[1], debug_step[1], debug_addr[1], uart_txd[1], busy[1]},
        {1'b0, 1'b0, 7'd0, 1'b1, 1'b0});
    tick(1);
    chk("midreset_en", {debug_en[1], busy[1], uart_txd[1]}, 3'b101);
    tick(60);
    chk("midreset_no_bytes", rxq[1].size(), 0);
    chk("midreset_no_done", dones[1], 0);

    // Single step without auto dump: 4 cycles high, 4 low, then idle.
    begin
      int hi, lo, i;
      clear_mon(0);
      hi = 0;
      lo = 0;
      step_req[0] = 1'b1;
      @(negedge clk);
      step_req[0] = 1'b0;
      for (i = 0; i < 40; i++) begin
        if (!busy[0]) break;
        if (debug_step[0]) hi++;
        else if (hi > 0) lo++;
        @(negedge clk);
      end
      chk("step_hi_len", hi, 4);
      chk("step_lo_len", lo, 4);
      chk("step_busy_fell", i < 40, 1);
      tick(30);
      chk("step_rises", rises[0], 1);
      chk("step_no_dump", {busy[0], 8'(rxq[0].size())}, 9'd0);
    end

    // Directed dump with fixed words.
    clear_mon(0);
    pulse(0, 1'b0, 1'b1);
    wait_done(0);
    tick(3);
    check_dump(0, "dump_fixed");
    chk("dump_fixed_dones", dones[0], 1);
    chk("dump_fixed_addr", debug_addr[0], 0);

    // Step and dump together with auto dump: one step, one dump.
    mem[0] = $urandom;
    mem[1] = $urandom;
    clear_mon(1);
    pulse(1, 1'b1, 1'b1);
    wait_done(1);
    tick(60);
    chk("both_rises", rises[1], 1);
    chk("both_dones", dones[1], 1);
    chk("both_idle", busy[1], 0);
    check_dump(1, "both");

    // Step requests during a dump are ignored.
    clear_mon(1);
    pulse(1, 1'b0, 1'b1);
    tick(100);
    pulse(1, 1'b1, 1'b0);
    tick(200);
    pulse(1, 1'b1, 1'b1);
    wait_done(1);
    tick(60);
    chk("ign_rises", rises[1], 0);
    chk("ign_dones", dones[1], 1);
    check_dump(1, "ign");

    // Randomized rounds on either instance with stray requests while busy.
    for (int r = 0; r < 4; r++) begin
      int   d;
      logic use_step;
      d        = int'($urandom_range(1, 0));
      use_step = (d == 1) && ($urandom_range(1, 0) == 1);
      mem[0]   = $urandom;
      mem[1]   = $urandom;
      if ($urandom_range(1, 0) == 1) mem[$urandom_range(1, 0)] = 32'hFFFF_FFFF;
      clear_mon(d);
      pulse(d, use_step, !use_step);
      tick(int'($urandom_range(150, 30)));
      pulse(d, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      wait_done(d);
      tick(60);
      chk($sformatf("rnd%0d_rises", r), rises[d], use_step ? 1 : 0);
      chk($sformatf("rnd%0d_dones", r), dones[d], 1);
      check_dump(d, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
